// File: rtl/module_mult_booth.sv
// ---------------------------------------------------------------------------
// module_mult_booth
//
// Purpose:
//   Sequential radix-2 Booth multiplier. Takes two signed two's-complement
//   operands from the upstream capture FSM and performs one Booth iteration
//   per clock. The signed 2*WIDTH-bit product is registered and held until
//   the next result is ready.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   valid       operand-valid level; only its rising edge starts an operation
//   numero1_i   multiplicand (signed, WIDTH bits)
//   numero2_i   multiplier (signed, WIDTH bits)
//   producto_o  registered signed product (2*WIDTH bits)
//   done_o      one-cycle pulse when producto_o has just been updated
//   busy_o      high while an operation is in progress (CALC or DONE)
//
// Configuration:
//   MULT_ZERO_SKIP_EN  when defined, a zero operand skips the iterations and
//                      goes directly to DONE with a zero product.
// ---------------------------------------------------------------------------
module module_mult_booth #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     numero1_i,
  input  logic [WIDTH-1:0]     numero2_i,
  output logic [2*WIDTH-1:0]   producto_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic             valid_d;
  logic             start;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  // A held-high valid must not retrigger, so only the rising edge counts.
  assign start = valid & ~valid_d;

  assign done_o = (state == DONE);
  assign busy_o = (state == CALC) || (state == DONE);

  // One Booth step: conditional add/subtract of M into A, then an arithmetic
  // right shift of {A,Q,q_m1}. A is one bit wider than the operands so that
  // subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    sum = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg - m_reg;
      default: sum = a_reg;
    endcase
    a_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next = {sum[0], q_reg[WIDTH-1:1]};
  end

  // Edge detector for valid, tracked in every state so that an edge seen
  // while busy is consumed and lost rather than deferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d <= 1'b0;
    end else begin
      valid_d <= valid;
    end
  end

  // Main control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
      producto_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= {numero1_i[WIDTH-1], numero1_i};
            q_reg <= numero2_i;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
`ifdef MULT_ZERO_SKIP_EN
            if ((numero1_i == '0) || (numero2_i == '0)) begin
              producto_o <= '0;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_m1  <= q_reg[0];
          count <= count - 1'b1;
          // The last iteration writes its shifted result straight into the
          // product register, so no extra cycle is spent copying it out.
          if (count == CW'(1)) begin
            producto_o <= {a_next[WIDTH-1:0], q_next};
            state      <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_mult_booth.sv
// ---------------------------------------------------------------------------
// tb_module_mult_booth
//
// Purpose:
//   Self-checking bench for module_mult_booth. Expected products come from
//   plain signed integer multiplication; expected latency and busy windows
//   come from the operation timing (WIDTH iterations, or immediate DONE for a
//   zero operand when MULT_ZERO_SKIP_EN is defined).
// ---------------------------------------------------------------------------
module tb_module_mult_booth;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;
  localparam int WIN   = 32;

  logic             clk;
  logic             rst;
  logic             valid;
  logic [WIDTH-1:0] numero1_i;
  logic [WIDTH-1:0] numero2_i;
  logic [PW-1:0]    producto_o;
  logic             done_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  module_mult_booth #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .numero1_i  (numero1_i),
    .numero2_i  (numero2_i),
    .producto_o (producto_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: ordinary signed multiplication, truncated to 2*WIDTH.
  function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    longint sx;
    longint sy;
    longint p;
    logic [PW-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    r  = p[PW-1:0];
    return r;
  endfunction

  // Number of clocks after the latch edge before done_o is seen.
  function automatic int ref_latency(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
`ifdef MULT_ZERO_SKIP_EN
    if ((x == '0) || (y == '0)) return 0;
`endif
    return WIDTH;
  endfunction

  function automatic logic [WIN-1:0] ref_busy(input int lat);
    logic [WIN-1:0] b;
    b = '0;
    for (int i = 0; i <= lat; i++) b[i] = 1'b1;
    return b;
  endfunction

  // Drives one operation and records what the DUT did over a fixed window.
  // Operands are scrambled mid-operation to show they are only sampled once.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output logic [PW-1:0] prod, output int first_done,
                        output int pulses, output logic [WIN-1:0] busy_bits);
    first_done = -1;
    pulses     = 0;
    busy_bits  = '0;
    prod       = '0;
    @(negedge clk);
    numero1_i = x;
    numero2_i = y;
    valid     = 1'b1;
    @(posedge clk);
    for (int k = 0; k < WIN; k++) begin
      #1;
      busy_bits[k] = busy_o;
      if (done_o) begin
        pulses++;
        if (first_done < 0) begin
          first_done = k;
          prod       = producto_o;
        end
      end
      if (k == 2) begin
        numero1_i = WIDTH'($urandom);
        numero2_i = WIDTH'($urandom);
      end
      @(posedge clk);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    valid     = 1'b0;
    numero1_i = '0;
    numero2_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (producto_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_product: got %h expected %h", producto_o, {PW{1'b0}});
    end
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got done=%b busy=%b expected 0 0", done_o, busy_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] xs [7] = '{8'd3, 8'hFB, 8'd99, 8'h80, 8'h80, 8'd6, 8'd1};
    logic [WIDTH-1:0] ys [7] = '{8'd4, 8'd7, 8'h9D, 8'h80, 8'd127, 8'd6, 8'hFF};
    logic [PW-1:0] want [7] = '{16'h000C, 16'hFFDD, 16'hD9B7, 16'h4000,
                                16'hC080, 16'h0024, 16'hFFFF};
    logic [PW-1:0]  prod;
    int             fd;
    int             np;
    logic [WIN-1:0] bb;
    for (int i = 0; i < 7; i++) begin
      run_op(xs[i], ys[i], prod, fd, np, bb);
      checks++;
      if (prod !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed_product[%0d]: got %h expected %h", i, prod, want[i]);
      end
      checks++;
      if (fd != WIDTH || np != 1) begin
        errors++;
        $display("[TB] FAIL directed_timing[%0d]: got done at %0d x%0d expected at %0d x1",
                 i, fd, np, WIDTH);
      end
      checks++;
      if (bb !== ref_busy(WIDTH)) begin
        errors++;
        $display("[TB] FAIL directed_busy[%0d]: got %b expected %b", i, bb, ref_busy(WIDTH));
      end
      checks++;
      if (producto_o !== want[i]) begin
        errors++;
        $display("[TB] FAIL directed_hold[%0d]: got %h expected %h", i, producto_o, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [PW-1:0]    prod;
    int               fd;
    int               np;
    logic [WIN-1:0]   bb;
    for (int i = 0; i < 40; i++) begin
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      run_op(x, y, prod, fd, np, bb);
      checks++;
      if (prod !== ref_product(x, y) || fd != ref_latency(x, y) || np != 1) begin
        errors++;
        $display("[TB] FAIL random[%0d] %h*%h: got %h at %0d x%0d expected %h at %0d x1",
                 i, x, y, prod, fd, np, ref_product(x, y), ref_latency(x, y));
      end
      checks++;
      if (bb !== ref_busy(ref_latency(x, y))) begin
        errors++;
        $display("[TB] FAIL random_busy[%0d]: got %b expected %b",
                 i, bb, ref_busy(ref_latency(x, y)));
      end
    end
  endtask

  task automatic test_held_valid();
    logic [PW-1:0]  prod;
    int             fd;
    int             np;
    logic [WIN-1:0] bb;
    run_op(8'd6, 8'd6, prod, fd, np, bb);
    checks++;
    if (np != 1 || prod !== 16'h0024) begin
      errors++;
      $display("[TB] FAIL held_valid: got %0d pulses product %h expected 1 pulse %h",
               np, prod, 16'h0024);
    end
  endtask

  task automatic test_retrigger();
    int            fd = -1;
    int            np = 0;
    logic [PW-1:0] prod = '0;
    @(negedge clk);
    numero1_i = 8'd5;
    numero2_i = 8'd9;
    valid     = 1'b1;
    @(posedge clk);
    for (int k = 0; k < WIN; k++) begin
      #1;
      if (done_o) begin
        np++;
        if (fd < 0) begin
          fd   = k;
          prod = producto_o;
        end
      end
      if (k == 2) valid = 1'b0;
      if (k == 3) begin
        valid     = 1'b1;
        numero1_i = 8'd11;
        numero2_i = 8'd13;
      end
      @(posedge clk);
    end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (prod !== ref_product(8'd5, 8'd9) || fd != WIDTH || np != 1) begin
      errors++;
      $display("[TB] FAIL retrigger: got %h at %0d x%0d expected %h at %0d x1",
               prod, fd, np, ref_product(8'd5, 8'd9), WIDTH);
    end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0]  prod;
    int             fd;
    int             np;
    logic [WIN-1:0] bb;
    @(negedge clk);
    numero1_i = 8'd7;
    numero2_i = 8'd7;
    valid     = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (producto_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got prod=%h done=%b busy=%b expected 0 0 0",
               producto_o, done_o, busy_o);
    end
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    run_op(8'd2, 8'hFD, prod, fd, np, bb);
    checks++;
    if (prod !== 16'hFFFA || fd != WIDTH || np != 1) begin
      errors++;
      $display("[TB] FAIL after_reset: got %h at %0d x%0d expected %h at %0d x1",
               prod, fd, np, 16'hFFFA, WIDTH);
    end
  endtask

  task automatic test_zero();
    logic [PW-1:0]  prod;
    int             fd;
    int             np;
    logic [WIN-1:0] bb;
    int             lat;
    lat = ref_latency(8'd0, 8'hB3);
    run_op(8'd0, 8'hB3, prod, fd, np, bb);
    checks++;
    if (prod !== '0 || fd != lat || np != 1) begin
      errors++;
      $display("[TB] FAIL zero_operand: got %h at %0d x%0d expected 0 at %0d x1",
               prod, fd, np, lat);
    end
    checks++;
    if (bb !== ref_busy(lat)) begin
      errors++;
      $display("[TB] FAIL zero_busy: got %b expected %b", bb, ref_busy(lat));
    end
    lat = ref_latency(8'd77, 8'd0);
    run_op(8'd77, 8'd0, prod, fd, np, bb);
    checks++;
    if (prod !== '0 || fd != lat || np != 1) begin
      errors++;
      $display("[TB] FAIL zero_multiplier: got %h at %0d x%0d expected 0 at %0d x1",
               prod, fd, np, lat);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_held_valid();
    test_retrigger();
    test_reset_mid();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_mult_booth.md
Name: module_mult_booth

Overview:
Sequential radix-2 Booth multiplier. It sits directly downstream of the data-capture FSM and consumes its two signed two's-complement operands and level valid. It produces a signed 2*WIDTH-bit product, which feeds the display/output stage. Each operation runs one Booth iteration per clock.

Parameters:
WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
valid  input  1  operands valid; a level that stays high for many cycles; rising edge starts a multiply
numero1_i  input  WIDTH  multiplicand, signed
numero2_i  input  WIDTH  multiplier, signed
producto_o  output  2*WIDTH  signed product, registered, held until next result
done_o  output  1  one-cycle pulse, producto_o valid and updated
busy_o  output  1  high while an operation is in progress (CALC or DONE)

Behaviour:
- Reset (rst=0, async): state=IDLE, producto_o=0, done_o=0, busy_o=0, internal A/Q/M/q_m1/count=0, valid_d=0.
- Start detect: valid_d <= valid every cycle; start = valid & ~valid_d. Only a rising edge starts an operation; a held-high valid never retriggers.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - A: WIDTH+1-bit accumulator. The extra bit prevents overflow when M = -2^(WIDTH-1).
  - Q: WIDTH-bit multiplier.
  - q_m1: 1 bit.
  - count: ceil(log2(WIDTH+1)) bits.
- FSM, states IDLE, CALC, DONE:
  - IDLE: on a start edge, latch M=sext(numero1_i), Q=numero2_i, A=0, q_m1=0, count=WIDTH; go to CALC.
  - CALC, per cycle:
    - {Q[0],q_m1}=01: A+M.
    - {Q[0],q_m1}=10: A-M.
    - 00/11: no add.
    - Then arithmetic shift right of {A,Q,q_m1} by one, with A's MSB replicated.
    - count decrements by 1.
    - On the cycle where count==1, load producto_o={A',Q'} (low 2*WIDTH bits of the post-shift {A,Q}) and go to DONE.
  - DONE: done_o=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: the operand-latch edge is cycle 0. CALC occupies cycles 1..WIDTH. producto_o updates and done_o rises at the edge ending cycle WIDTH. For WIDTH=8, done_o is high 9 cycles after the latch edge.
- busy_o = (state==CALC) | (state==DONE).
- Start edge during CALC/DONE is ignored; the operation is not restarted and the operands are not re-latched. valid_d still tracks, so that edge is lost.
- Start edge in the same cycle as DONE is ignored. A new operation needs valid to fall and rise again while in IDLE.
- Operands are sampled only at the latch edge; changes on numero1_i/numero2_i afterwards have no effect.
- Result range: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which fits signed 2*WIDTH bits. No saturation is needed.
- Reset mid-operation aborts immediately to the reset values. producto_o is cleared to 0.

Optional Feature:
MULT_ZERO_SKIP_EN
- Defined: at the latch edge, if numero1_i==0 or numero2_i==0, go straight to DONE with producto_o=0. done_o is then high one cycle after the latch edge, and busy_o is high for that single DONE cycle.
- Undefined: zero operands take the full WIDTH-iteration path. Latency is always WIDTH+1.

Test Plan:
- numero1_i=3, numero2_i=4, valid 0->1 -> done_o one cycle, 9 cycles after latch; producto_o=16'h000C; busy_o high cycles 1..9.
- numero1_i=-5 (8'hFB), numero2_i=7 -> producto_o=16'hFFDD (-35). numero1_i=99, numero2_i=-99 -> producto_o=16'hD9B7 (-9801).
- numero1_i=-128, numero2_i=-128 -> producto_o=16'h4000. numero1_i=-128, numero2_i=127 -> producto_o=16'hC080.
- valid held high 30 cycles with 6*6 -> exactly one done_o pulse, producto_o=16'h0024. A second 0->1 edge during CALC -> ignored; the result reflects the first operands only.
- rst=0 asserted at CALC cycle 4 -> producto_o=0, done_o=0, busy_o=0 immediately. After release, a new start with 2*-3 -> producto_o=16'hFFFA.
- Zero operand 0*-77: with MULT_ZERO_SKIP_EN -> done_o 1 cycle after latch, producto_o=0; without it -> done_o after 9 cycles, producto_o=0.
